// File: rtl/trellis_hard_decoder.sv
// trellis_hard_decoder: hard-decision Viterbi decoder for the 8-state LTE
// constituent RSC code (feedback 1+D^2+D^3, parity 1+D+D^3). Each accepted
// (xk, zk) pair advances one add-compare-select step. The survivor is then
// traced back from state 0 into a bit buffer, and the K bits are streamed out.
module trellis_hard_decoder #(
   parameter int KMAX = 512,
   parameter int LW   = 13,
   parameter int PM_W = 10
) (
   input  logic            clk,
   input  logic            aclr,
   input  logic [LW-1:0]   blk_len,
   input  logic            in_valid,
   input  logic            xk,
   input  logic            zk,
   output logic            in_ready,
   output logic            ck,
   output logic            ck_valid,
   output logic            ck_last,
   output logic            busy,
   output logic [PM_W-1:0] path_dist
);
   localparam int AW = $clog2(KMAX + 3);
   localparam int OW = $clog2(KMAX);
   localparam logic [LW-1:0] KMAX_L = LW'(KMAX);

   typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;

   state_t          state, state_nx;
   logic [LW-1:0]   k, step, idx;
   logic [2:0]      tn;
   logic [PM_W-1:0] pm     [8];
   logic [PM_W-1:0] pm_src [8];
   logic [PM_W-1:0] pm_new [8];
   logic [7:0]      dec_new;
   logic [7:0]      dec_ram [KMAX+3];
   logic [KMAX-1:0] out_buf;
   logic [AW-1:0]   wr_addr;
   logic            accept, last_step, d_tr, c_tr;

   // Block length of zero means one bit; anything above KMAX is capped.
   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
      if (len == '0) return LW'(1);
      if (len > KMAX_L) return KMAX_L;
      return len;
   endfunction

   // Modulo-2^PM_W ordering: a is smaller when (a - b) has its MSB set.
   function automatic logic pm_less(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
      logic [PM_W-1:0] diff;
      diff = a - b;
      return diff[PM_W-1];
   endfunction

   assign accept    = in_valid && in_ready;
   assign last_step = (step == k + LW'(2));
   assign wr_addr   = (state == IDLE) ? '0 : step[AW-1:0];
   assign d_tr      = dec_ram[step[AW-1:0]][tn];
   assign c_tr      = tn[2] ^ tn[0] ^ d_tr;

   // Add-compare-select for all 8 next states; IDLE substitutes the start metrics
   always_comb begin
      logic [2:0]      n3;
      logic            c0, p0;
      logic [1:0]      bm0, bm1;
      logic [PM_W-1:0] m0, m1;
      n3 = '0; c0 = 1'b0; p0 = 1'b0; bm0 = '0; bm1 = '0; m0 = '0; m1 = '0;
      dec_new = '0;
      for (int n = 0; n < 8; n++) begin
         pm_src[n] = (state == IDLE) ? ((n == 0) ? '0 : PM_W'(15)) : pm[n];
      end
      for (int n = 0; n < 8; n++) begin
         n3  = 3'(n);
         c0  = n3[2] ^ n3[0];
         p0  = n3[2] ^ n3[1];
         bm0 = {1'b0, xk ^ c0} + {1'b0, zk ^ p0};
         bm1 = {1'b0, xk ^ ~c0} + {1'b0, zk ^ ~p0};
         m0  = pm_src[{n3[1:0], 1'b0}] + PM_W'(bm0);
         m1  = pm_src[{n3[1:0], 1'b1}] + PM_W'(bm1);
         dec_new[n] = pm_less(m1, m0);
         pm_new[n]  = dec_new[n] ? m1 : m0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (aclr) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state and handshake decode
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ACS;
         end
         ACS: begin
            in_ready = 1'b1;
            if (in_valid && last_step) state_nx = TRACE;
         end
         TRACE: if (step == '0) state_nx = OUT;
         OUT:   if (ck_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Metrics, decision RAM and traceback buffer
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int n = 0; n < 8; n++) pm[n] <= pm_new[n];
         dec_ram[wr_addr] <= dec_new;
      end
      if (state == TRACE && step < k) out_buf[step[OW-1:0]] <= c_tr;
   end

   // Step counters, traceback state and output registers
   always_ff @(posedge clk) begin
      if (aclr) begin
         k         <= '0;
         step      <= '0;
         idx       <= '0;
         tn        <= '0;
         busy      <= 1'b0;
         ck        <= 1'b0;
         ck_valid  <= 1'b0;
         ck_last   <= 1'b0;
         path_dist <= '0;
      end else begin
         ck_valid <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               k    <= clamp_len(blk_len);
               step <= LW'(1);
               busy <= 1'b1;
            end
            ACS: if (in_valid) begin
               if (last_step) begin
                  path_dist <= pm_new[0];
                  tn        <= '0;
               end else begin
                  step <= step + LW'(1);
               end
            end
            TRACE: begin
               tn <= {tn[1:0], d_tr};
               if (step == '0) idx <= '0;
               else            step <= step - LW'(1);
            end
            OUT: if (ck_last) begin
               ck_last <= 1'b0;
               busy    <= 1'b0;
            end else begin
               ck       <= out_buf[idx[OW-1:0]];
               ck_valid <= 1'b1;
               ck_last  <= (idx == k - LW'(1));
               idx      <= idx + LW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/trellis_hard_decoder.md
Name: trellis_hard_decoder

Overview:
- Hard-decision Viterbi decoder for the 8-state LTE constituent RSC code: feedback g0 = 1+D^2+D^3, parity g1 = 1+D+D^3.
- Receive-side counterpart of the turbo encoder chain. It takes the systematic/parity bit pairs of constituent encoder 1, K data steps followed by 3 trellis-termination steps, and recovers the K information bits c_k.
- Used as the first-stage decoder and as a loopback checker for the encoder/tail-processor path.

Parameters:
KMAX, 512, maximum block length in information bits; sizes the decision RAM (KMAX+3 words x 8 bits) and the output bit buffer (KMAX bits)
LW, 13, width of blk_len
PM_W, 10, path-metric width; compared modulo 2^PM_W

Ports:
clk  input  1  system clock, all logic rising-edge
aclr  input  1  reset, synchronous, active-high
blk_len  input  LW  information block length K, sampled with the first accepted symbol of a block
in_valid  input  1  xk/zk pair present
xk  input  1  received systematic bit (hard decision)
zk  input  1  received parity bit (hard decision)
in_ready  output  1  decoder accepts a symbol this cycle
ck  output  1  decoded information bit
ck_valid  output  1  ck is valid this cycle
ck_last  output  1  marks bit K-1 of the block
busy  output  1  high from first accepted symbol until after ck_last
path_dist  output  PM_W  final state-0 metric, i.e. Hamming disagreements on the survivor path

Behaviour:
- Reset (aclr=1 at an edge), from any state including mid-block:
  - FSM goes to IDLE.
  - in_ready=1; ck, ck_valid, ck_last, busy = 0; path_dist = 0.
  - Metrics re-initialise at the next block start. RAM contents are don't-care.
- State encoding: s = 4*s1 + 2*s2 + s3.
- Predecessors of next state n: p = ((n&3)<<1) | d, with d in {0,1} as the decision bit.
- Branch labels:
  - Input c = n[2]^n[0]^d; expected systematic = c.
  - Expected parity = n[2]^n[1]^d.
  - Branch metric = Hamming distance (0..2) to the received (xk, zk).
- FSM states: IDLE, ACS, TRACE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch K = blk_len (0 -> 1, >KMAX -> KMAX).
  - Initialise PM[0]=0 and PM[1..7]=15, then process this symbol as step 0 in the same cycle.
  - busy rises on the next edge; go to ACS.
- ACS:
  - in_ready=1. One step per accepted symbol; in_valid gaps stall with no metric change.
  - For each n: PM'[n] = min over d of (PM[p]+BM). Write d into decision RAM word t, bit n.
  - Compare is modulo 2^PM_W: a<b iff (a-b) MSB is 1. Tie selects d=0.
  - After step t = K+2 is accepted: latch path_dist = PM'[0], drop in_ready, go to TRACE.
  - Tail steps use the same ACS. Traceback from state 0 enforces termination.
- TRACE:
  - in_ready=0. Start at n=0, t=K+2; one step per cycle, K+3 cycles total.
  - Each step: read d = RAM[t][n]; if t<K, write c = n[2]^n[0]^d into out_buf[t]; set n = p; decrement t.
  - After t=0, go to OUT.
- OUT:
  - in_ready=0. Emit out_buf[0..K-1], one bit per cycle with ck_valid=1 and no backpressure.
  - ck_last=1 with bit K-1.
  - Next cycle: busy=0, in_ready=1, go to IDLE. path_dist holds until the next block start.
- Latency from last tail symbol accepted to first ck_valid: K+4 cycles.
- Back-to-back blocks: a symbol offered while in_ready=0 is not consumed, and the source holds it.
- Metric spread stays below 2^(PM_W-1) for PM_W>=6, so no normalisation is needed.

Test Plan:
- Clean vector: K=4, bits 1,0,1,1 -> feed xk=1,0,1,1,0,0,0 and zk=1,1,0,1,0,0,0 -> ck=1,0,1,1; ck_last on 4th bit; path_dist=0; first ck_valid 8 cycles after 7th symbol accepted.
- Single error: same vector with zk[1] flipped to 0 -> ck=1,0,1,1, path_dist=1. Also with xk[0] flipped to 0 -> same bits, path_dist=1.
- All-zero block: K=KMAX, xk=zk=0 for KMAX+3 symbols -> KMAX zeros; ck_last on last; path_dist=0; busy spans exactly to ck_last+1.
- Reset mid-block: assert aclr during ACS at step 2 -> next cycle in_ready=1, busy=0, no ck_valid. A fresh K=4 clean block then decodes to 1,0,1,1.
- Handshake: insert random in_valid gaps during ACS and offer symbols during TRACE/OUT -> identical output to gap-free run; no symbol consumed while in_ready=0.
- Length clamping: blk_len=0 -> block of 4 symbols, 1 output bit; blk_len=KMAX+5 -> KMAX output bits.
